// File: rtl/neopixel_pkg.sv
// ============================================================================
// Module   : neopixel_pkg
// Purpose  : Default WS2812 timing constants and the transmitter state enum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package neopixel_pkg;

  localparam int c_T_BIT   = 20;
  localparam int c_T0H     = 6;
  localparam int c_T1H     = 13;
  localparam int c_T_LATCH = 1280;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module   : sync_edge
// Purpose  : Two-flop synchronizer followed by a rising-edge pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_pulse
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  // Edges are only trusted once the pipe holds real samples, so a level that
  // was already high across reset release does not look like a new edge.
  assign o_pulse = r_sync & ~r_prev & (r_fill == 2'd3);

endmodule

`default_nettype wire

// File: rtl/neopixel_tx.sv
// ============================================================================
// Module   : neopixel_tx
// Purpose  : WS2812 single-wire frame transmitter with end-of-frame latch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neopixel_tx
  import neopixel_pkg::*;
#(
  parameter int NUM_LEDS = 24,
  parameter int T_BIT    = c_T_BIT,
  parameter int T0H      = c_T0H,
  parameter int T1H      = c_T1H,
  parameter int T_LATCH  = c_T_LATCH
) (
  input  logic                    clk_16MHz,
  input  logic                    rst_n,
  input  logic                    start_tx,
  input  logic [24*NUM_LEDS-1:0]  data_in,
  output logic                    dout,
  output logic                    busy
);

  localparam int c_NB   = 24 * NUM_LEDS;
  localparam int c_CMAX = (T_BIT > T_LATCH) ? T_BIT : T_LATCH;
  localparam int c_CW   = $clog2(c_CMAX + 1);
  localparam int c_BW   = $clog2(c_NB + 1);

  localparam logic [c_CW-1:0] c_T0H_M1   = c_CW'(T0H - 1);
  localparam logic [c_CW-1:0] c_T1H_M1   = c_CW'(T1H - 1);
  localparam logic [c_CW-1:0] c_TBIT_M1  = c_CW'(T_BIT - 1);
  localparam logic [c_CW-1:0] c_TLAT_M1  = c_CW'(T_LATCH - 1);
  localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(c_NB - 1);

  state_t            r_state,  w_state_nx;
  logic [c_CW-1:0]   r_cyc,    w_cyc_nx;
  logic [c_BW-1:0]   r_bit,    w_bit_nx;
  logic [c_NB-1:0]   r_shreg,  w_shreg_nx;
  logic              r_dout;
  logic              r_busy;
  logic              w_start;
  logic [c_CW-1:0]   w_high_m1;

  sync_edge u_sync (
    .clk     (clk_16MHz),
    .rst_n   (rst_n),
    .i_d     (start_tx),
    .o_pulse (w_start)
  );

  assign w_high_m1 = r_shreg[c_NB-1] ? c_T1H_M1 : c_T0H_M1;

  always_comb begin
    w_state_nx = r_state;
    w_cyc_nx   = r_cyc;
    w_bit_nx   = r_bit;
    w_shreg_nx = r_shreg;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_shreg_nx = data_in;
          w_cyc_nx   = '0;
          w_bit_nx   = '0;
          w_state_nx = ST_HIGH;
        end
      end
      ST_HIGH: begin
        w_cyc_nx = r_cyc + 1'b1;
        if (r_cyc == w_high_m1) w_state_nx = ST_LOW;
      end
      ST_LOW: begin
        if (r_cyc == c_TBIT_M1) begin
          w_cyc_nx = '0;
          if (r_bit == c_LAST_BIT) begin
            w_state_nx = ST_LATCH;
          end else begin
            w_bit_nx   = r_bit + 1'b1;
            w_shreg_nx = {r_shreg[c_NB-2:0], 1'b0};
            w_state_nx = ST_HIGH;
          end
        end else begin
          w_cyc_nx = r_cyc + 1'b1;
        end
      end
      ST_LATCH: begin
        if (r_cyc == c_TLAT_M1) begin
          w_cyc_nx   = '0;
          w_state_nx = ST_IDLE;
        end else begin
          w_cyc_nx = r_cyc + 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // dout trails the state by one register stage so it never sees an input.
  always_ff @(posedge clk_16MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cyc   <= w_cyc_nx;
      r_bit   <= w_bit_nx;
      r_shreg <= w_shreg_nx;
      r_dout  <= (r_state == ST_HIGH);
      r_busy  <= (w_state_nx != ST_IDLE);
    end
  end

  assign dout = r_dout;
  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_neopixel_tx.sv
// ============================================================================
// Module   : tb_neopixel_tx
// Purpose  : Directed/randomized bench comparing the serial waveform with a
//            bit-level reference computed from the pixel data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neopixel_tx;

  localparam int N       = 8;
  localparam int W       = 24 * N;
  localparam int T_BIT   = 20;
  localparam int T0H     = 6;
  localparam int T1H     = 13;
  localparam int T_LATCH = 1280;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_tx;
  logic [W-1:0] data_in;
  logic         dout;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #31 clk = ~clk;

  neopixel_tx #(.NUM_LEDS(N)) u_dut (
    .clk_16MHz (clk),
    .rst_n     (rst_n),
    .start_tx  (start_tx),
    .data_in   (data_in),
    .dout      (dout),
    .busy      (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W / 32; k++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic idle_check(input string tag, input int cycles);
    int highs, busys;
    highs = 0;
    busys = 0;
    for (int k = 0; k < cycles; k++) begin
      wait_cyc();
      highs += int'(dout);
      busys += int'(busy);
    end
    chk({tag, "_dout"}, highs, 0);
    chk({tag, "_busy"}, busys, 0);
  endtask

  // mode 0 plain, 1 re-trigger at bit 10, 2 data change at bit 5,
  // 3 edge exactly as busy falls, 4 reset at bit 100
  task automatic run_frame(input logic [W-1:0] d, input int mode, input int pre);
    int busy_cnt, highs, h;
    logic [31:0] pat, expp;
    data_in  = d;
    start_tx = 1'b0;
    repeat (pre) @(posedge clk);
    @(negedge clk);
    start_tx = 1'b1;
    @(posedge clk);
    #1;
    busy_cnt = int'(busy);
    chk("e0_dout", int'(dout), 0);
    chk("e0_busy", int'(busy), 0);
    wait_cyc();
    busy_cnt += int'(busy);
    chk("e1_dout", int'(dout), 0);
    chk("e1_busy", int'(busy), 0);
    wait_cyc();
    busy_cnt += int'(busy);
    chk("e2_dout", int'(dout), 0);
    chk("e2_busy", int'(busy), 1);
    for (int i = 0; i < W; i++) begin
      h    = d[W-1-i] ? T1H : T0H;
      pat  = '0;
      expp = '0;
      for (int j = 0; j < T_BIT; j++) begin
        wait_cyc();
        busy_cnt += int'(busy);
        pat  = {pat[30:0], dout};
        expp = {expp[30:0], (j < h)};
        if (mode == 1 && i == 10 && j == 0)  start_tx = 1'b0;
        if (mode == 1 && i == 10 && j == 10) start_tx = 1'b1;
        if (mode == 2 && i == 5 && j == 0)   data_in = '0;
        if (mode == 3 && i == 0 && j == 0)   start_tx = 1'b0;
        if (mode == 4 && i == 100 && j == 3) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_dout", int'(dout), 0);
          chk("rst_busy", int'(busy), 0);
          return;
        end
      end
      chk($sformatf("bit%0d", i), int'(pat), int'(expp));
    end
    highs = 0;
    for (int l = 0; l < T_LATCH; l++) begin
      wait_cyc();
      busy_cnt += int'(busy);
      highs    += int'(dout);
      if (mode == 3 && l == T_LATCH - 4) begin
        @(negedge clk);
        start_tx = 1'b1;
      end
    end
    chk("latch_high", highs, 0);
    chk("busy_len", busy_cnt, W * T_BIT + T_LATCH);
    chk("busy_end", int'(busy), 0);
    idle_check("post", 60);
  endtask

  initial begin
    logic [W-1:0] r;
    rst_n    = 1'b0;
    start_tx = 1'b0;
    data_in  = '0;
    #5;
    chk("reset_dout", int'(dout), 0);
    chk("reset_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame({N{24'h00FF00}}, 0, 4);
    run_frame({W{1'b1}}, 0, 4);
    r = rand_data();
    run_frame(r, 1, 4);
    r = rand_data();
    run_frame(r, 2, 4);
    r = rand_data();
    run_frame(r, 3, 4);
    r = rand_data();
    run_frame(r, 0, 4);
    r = rand_data();
    run_frame(r, 4, 4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("held_high", 300);
    r = rand_data();
    run_frame(r, 0, 4);

    @(negedge clk);
    rst_n    = 1'b0;
    start_tx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r = rand_data();
    run_frame(r, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
